shift_exec_unit: RTL

Multi-cycle shift execution stage that sits directly upstream of the 32-bit barrel shifter and drives its D, S and LnR inputs. It accepts shift and rotate requests over a valid/ready handshake and time-multiplexes one barrel shifter, using one pass for logical shifts and two passes for rotates. It returns a registered result over a second valid/ready handshake to the ALU result mux.

---
 rtl/shift_exec_unit_if.sv | 37 +++
 rtl/shift_exec_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/shift_exec_unit_if.sv
// Request/result bus of the shift execution stage.
// The master side issues shift/rotate requests and consumes results.
// The slave side is the execution unit itself.
interface shift_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       IN_OP;
    logic [WIDTH-1:0] IN_D;
    logic [WIDTH-1:0] IN_S;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_Y;

    modport master (
        output IN_VALID,
        input  IN_READY,
        output IN_OP,
        output IN_D,
        output IN_S,
        input  OUT_VALID,
        output OUT_READY,
        input  OUT_Y
    );

    modport slave (
        input  IN_VALID,
        output IN_READY,
        input  IN_OP,
        input  IN_D,
        input  IN_S,
        output OUT_VALID,
        input  OUT_READY,
        output OUT_Y
    );
endinterface

// File: rtl/shift_exec_unit.sv
// Multi-cycle shift execution stage.
// A single external barrel shifter is time-multiplexed across passes:
// - logical shifts take one pass;
// - rotates take two passes. The first pass shifts by k. The second pass
//   shifts by 32-k in the opposite direction, and its result is ORed with
//   the first.
// Results are registered and held until the consumer takes them.
module shift_exec_unit #(
    parameter int WIDTH     = 32,
    parameter int SAMT_BITS = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    shift_exec_unit_if.slave     bus,
    output logic                 BUSY,
    output logic [WIDTH-1:0]     SH_D,
    output logic [SAMT_BITS-1:0] SH_S,
    output logic                 SH_LNR,
    input  logic [WIDTH-1:0]     SH_Y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_t;

    state_t               stateReg;
    state_t               stateNext;
    op_t                  opReg;
    logic [WIDTH-1:0]     dReg;
    logic [SAMT_BITS-1:0] kReg;
    logic                 bigReg;
    logic [WIDTH-1:0]     partialReg;
    logic [WIDTH-1:0]     outYReg;

    logic                 captureEn;
    logic                 partialLoad;
    logic                 outLoad;
    logic [WIDTH-1:0]     outYNext;

    logic                 isLeft;
    logic                 isRotate;

    // Direction of the first pass: left for SLL and ROL.
    assign isLeft   = (opReg == OP_SLL) || (opReg == OP_ROL);
    // The top bit of the opcode selects the rotate family.
    assign isRotate = opReg[1];

    // State, captured operands, partial rotate term and result register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg   <= IDLE;
            opReg      <= OP_SLL;
            dReg       <= '0;
            kReg       <= '0;
            bigReg     <= 1'b0;
            partialReg <= '0;
            outYReg    <= '0;
        end else begin
            stateReg <= stateNext;
            if (captureEn) begin
                opReg  <= op_t'(bus.IN_OP);
                dReg   <= bus.IN_D;
                kReg   <= bus.IN_S[SAMT_BITS-1:0];
                bigReg <= |bus.IN_S[WIDTH-1:SAMT_BITS];
            end
            if (partialLoad) begin
                partialReg <= SH_Y;
            end
            if (outLoad) begin
                outYReg <= outYNext;
            end
        end
    end

    // Drive the barrel shifter from registered state only.
    // This keeps the SH_* -> SH_Y path free of feedback.
    always_comb begin
        SH_D   = '0;
        SH_S   = '0;
        SH_LNR = 1'b0;
        case (stateReg)
            PASS1: begin
                SH_D   = dReg;
                SH_S   = kReg;
                SH_LNR = isLeft;
            end
            PASS2: begin
                SH_D   = dReg;
                // 32-k taken modulo 32; k is nonzero here, so this is 1..31.
                SH_S   = ~kReg + {{(SAMT_BITS-1){1'b0}}, 1'b1};
                SH_LNR = ~isLeft;
            end
            default: begin
                SH_D   = '0;
                SH_S   = '0;
                SH_LNR = 1'b0;
            end
        endcase
    end

    // Next-state and datapath load decisions.
    always_comb begin
        stateNext   = stateReg;
        captureEn   = 1'b0;
        partialLoad = 1'b0;
        outLoad     = 1'b0;
        outYNext    = outYReg;
        case (stateReg)
            IDLE: begin
                if (bus.IN_VALID) begin
                    captureEn = 1'b1;
                    stateNext = PASS1;
                end
            end
            PASS1: begin
                if (!isRotate) begin
                    // An oversized logical shift clears every bit.
                    // The shifter output is unused in that case.
                    outLoad   = 1'b1;
                    outYNext  = bigReg ? '0 : SH_Y;
                    stateNext = DONE;
                end else if (kReg == '0) begin
                    // A rotate by a multiple of 32 is the identity.
                    outLoad   = 1'b1;
                    outYNext  = dReg;
                    stateNext = DONE;
                end else begin
                    partialLoad = 1'b1;
                    stateNext   = PASS2;
                end
            end
            PASS2: begin
                outLoad   = 1'b1;
                outYNext  = partialReg | SH_Y;
                stateNext = DONE;
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the state register.
    assign bus.IN_READY  = (stateReg == IDLE);
    assign bus.OUT_VALID = (stateReg == DONE);
    assign bus.OUT_Y     = outYReg;
    assign BUSY          = (stateReg != IDLE);

endmodule
